// File: rtl/wrpg_pkg.sv
// Shared types and constants for the WRPG weighted pattern generator.
package wrpg_pkg;

   localparam int unsigned LFSR_W = 16;

   // Reset value, and replacement for an all-zero seed (the lockup state)
   localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

   // Feedback taps for x^16+x^14+x^13+x^11+1: r[15], r[13], r[12], r[10]
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      W_HALF = 2'b00,
      W_QTR  = 2'b01,
      W_3QTR = 2'b10,
      W_8TH  = 2'b11
   } weight_e;

   typedef enum logic [1:0] {
      IDLE,
      SEED,
      RUN,
      DONE
   } state_e;

   // Combine up to three LFSR bits so the result is 1 with probability 1/2, 1/4, 3/4 or 1/8
   function automatic logic weight_bit(input logic [1:0] code, input logic a, input logic b,
                                       input logic c);
      logic w;
      w = a;
      case (weight_e'(code))
         W_HALF: w = a;
         W_QTR:  w = a & b;
         W_3QTR: w = a | b;
         W_8TH:  w = a & b & c;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/wrpg_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load and zero-seed substitution.
module wrpg_lfsr16
   import wrpg_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              step,
   output logic [LFSR_W-1:0] r
);

   logic fb;

   assign fb = ^(r & LFSR_TAPS);

   // Shift register: load wins over step; a zero seed would lock up, so substitute the default
   always_ff @(posedge clk) begin
      if (rst) begin
         r <= LFSR_DEFAULT_SEED;
      end else if (load) begin
         r <= (seed == '0) ? LFSR_DEFAULT_SEED : seed;
      end else if (step) begin
         r <= {r[LFSR_W-2:0], fb};
      end
   end

endmodule

// File: rtl/wrpg_weight_gen.sv
// Weighted random pattern source for the WRPG pattern register.
// Emits NUM_PAT weighted LFSR patterns per start, then pulses done.
// Optional build macro WRPG_BYPASS_EN adds a bypass input that passes raw LFSR bits.
module wrpg_weight_gen
   import wrpg_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned NUM_PAT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LFSR_W-1:0]    seed,
   input  logic [2*WIDTH-1:0]   weights,
   input  logic                 hold,
`ifdef WRPG_BYPASS_EN
   input  logic                 bypass,
`endif
   output logic [WIDTH-1:0]     pat,
   output logic                 pat_en,
   output logic                 busy,
   output logic                 done
);

   localparam logic [LFSR_W-1:0] LAST_IDX = LFSR_W'(NUM_PAT - 1);

   state_e            state;
   state_e            next_state;
   logic [LFSR_W-1:0] r;
   logic [LFSR_W-1:0] cnt;
   logic              lfsr_load;
   logic              run_step;
   logic [WIDTH-1:0]  weighted;
   logic [WIDTH-1:0]  pat_src;

   wrpg_lfsr16 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (lfsr_load),
      .seed (seed),
      .step (run_step),
      .r    (r)
   );

   // Per-bit bias: a from the low byte, b and c from the high byte
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int unsigned C_IDX = ((i + 4) % 8) + 8;
      assign weighted[i] = weight_bit(weights[2*i+1 -: 2], r[i], r[i+8], r[C_IDX]);
   end

`ifdef WRPG_BYPASS_EN
   assign pat_src = bypass ? r[WIDTH-1:0] : weighted;
`else
   assign pat_src = weighted;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and per-cycle control decode
   always_comb begin
      next_state = state;
      lfsr_load  = 1'b0;
      run_step   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               lfsr_load  = 1'b1;
               next_state = SEED;
            end
         end
         SEED: next_state = RUN;
         RUN: begin
            if (!hold) begin
               run_step = 1'b1;
               if (cnt == LAST_IDX) begin
                  next_state = DONE;
               end
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Registered outputs and pattern counter; pat holds its value except on a generating cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         pat    <= '0;
         pat_en <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         cnt    <= '0;
      end else begin
         pat_en <= run_step;
         done   <= (state == DONE);
         busy   <= (next_state == SEED) || (next_state == RUN);
         if (lfsr_load) begin
            cnt <= '0;
         end else if (run_step) begin
            cnt <= cnt + 16'd1;
         end
         if (run_step) begin
            pat <= pat_src;
         end
      end
   end

endmodule

// File: tb/tb_wrpg_weight_gen.sv
// Directed, table-driven bench for wrpg_weight_gen (NUM_PAT=4, WIDTH=8).
module tb_wrpg_weight_gen;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] seed;
   logic [15:0] weights;
   logic        hold;
`ifdef WRPG_BYPASS_EN
   logic        bypass;
`endif
   logic [7:0]  pat;
   logic        pat_en;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   wrpg_weight_gen #(.WIDTH(8), .NUM_PAT(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .seed    (seed),
      .weights (weights),
      .hold    (hold),
`ifdef WRPG_BYPASS_EN
      .bypass  (bypass),
`endif
      .pat     (pat),
      .pat_en  (pat_en),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] seed;
      logic [15:0] weights;
      logic [7:0]  exp0;
      logic [7:0]  exp1;
   } vec_t;

   vec_t vecs[6];

   // Results of the most recent run
   logic [7:0] pats[8];
   int en_cnt, done_cnt, first_idx, last_idx, done_idx;
   logic busy_at_first, busy_at_done, hold_ok;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Start one run, then observe 40 cycles at negedge; optionally hold after the first
   // pattern, or fire an extra start after the second pattern
   task automatic run_collect(input logic [15:0] s, input logic [15:0] w, input int hold_len,
                              input bit restart);
      int  hold_left;
      bit  hold_started;
      bit  rs_done;
      hold_left = 0; hold_started = 0; rs_done = 0;
      en_cnt = 0; done_cnt = 0; first_idx = -1; last_idx = -1; done_idx = -1;
      busy_at_first = 1'bx; busy_at_done = 1'bx; hold_ok = 1'b1;
      for (int k = 0; k < 8; k++) pats[k] = 8'h00;
      @(negedge clk);
      seed = s; weights = w; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (pat_en) begin
            if (en_cnt < 8) pats[en_cnt] = pat;
            if (en_cnt == 0) begin
               first_idx = c;
               busy_at_first = busy;
            end
            last_idx = c;
            en_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_idx = c;
            busy_at_done = busy;
         end
         if (hold_len > 0 && en_cnt == 1 && !hold_started) begin
            hold = 1'b1; hold_started = 1; hold_left = hold_len;
         end else if (hold_left > 0) begin
            if (pat_en || pat !== pats[0]) hold_ok = 1'b0;
            hold_left--;
            if (hold_left == 0) hold = 1'b0;
         end
         if (restart && en_cnt == 2 && !rs_done) begin
            start = 1'b1; seed = 16'h1234; rs_done = 1;
         end
      end
      hold = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      int n;
      int bad;

      vecs[0] = '{16'h00A5, 16'h0000, 8'hA5, 8'h4A};
      vecs[1] = '{16'hFF0F, 16'h5555, 8'h0F, 8'h1E};
      vecs[2] = '{16'h0F00, 16'hAAAA, 8'h0F, 8'h1F};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 8'hFF, 8'hFE};
      vecs[4] = '{16'h0000, 16'h0000, 8'hE1, 8'hC3};
      vecs[5] = '{16'h3C5A, 16'hE4E4, 8'h54, 8'h75};

      rst = 1'b1; start = 1'b0; seed = 16'h0; weights = 16'h0; hold = 1'b0;
`ifdef WRPG_BYPASS_EN
      bypass = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("reset_pat", 32'(pat), 32'h0);
      check("reset_pat_en", 32'(pat_en), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_done", 32'(done), 32'h0);
      rst = 1'b0;
      // Hold outside RUN must not matter
      hold = 1'b1;
      repeat (2) @(negedge clk);
      hold = 1'b0;

      // Table: first two patterns, count, latency and done placement per seed/weight pair
      for (int v = 0; v < 6; v++) begin
         run_collect(vecs[v].seed, vecs[v].weights, 0, 0);
         check($sformatf("v%0d_pat0", v), 32'(pats[0]), 32'(vecs[v].exp0));
         check($sformatf("v%0d_pat1", v), 32'(pats[1]), 32'(vecs[v].exp1));
         check($sformatf("v%0d_en_cnt", v), 32'(en_cnt), 32'd4);
         check($sformatf("v%0d_first_idx", v), 32'(first_idx), 32'd1);
         check($sformatf("v%0d_last_idx", v), 32'(last_idx), 32'd4);
         check($sformatf("v%0d_done_cnt", v), 32'(done_cnt), 32'd1);
         check($sformatf("v%0d_done_idx", v), 32'(done_idx), 32'd5);
         check($sformatf("v%0d_busy_first", v), 32'(busy_at_first), 32'd1);
         check($sformatf("v%0d_busy_done", v), 32'(busy_at_done), 32'd0);
      end

      // Full sequence for seed 00A5
      run_collect(16'h00A5, 16'h0000, 0, 0);
      check("seq_pat2", 32'(pats[2]), 32'h94);
      check("seq_pat3", 32'(pats[3]), 32'h28);

      // Hold for 3 cycles after the first pattern
      run_collect(16'h00A5, 16'h0000, 3, 0);
      check("hold_stable", 32'(hold_ok), 32'd1);
      check("hold_pat1", 32'(pats[1]), 32'h4A);
      check("hold_pat3", 32'(pats[3]), 32'h28);
      check("hold_en_cnt", 32'(en_cnt), 32'd4);
      check("hold_last_idx", 32'(last_idx), 32'd7);
      check("hold_done_idx", 32'(done_idx), 32'd8);

      // Second start during RUN is ignored
      run_collect(16'h00A5, 16'h0000, 0, 1);
      check("restart_en_cnt", 32'(en_cnt), 32'd4);
      check("restart_pat2", 32'(pats[2]), 32'h94);
      check("restart_pat3", 32'(pats[3]), 32'h28);
      check("restart_done_cnt", 32'(done_cnt), 32'd1);
      repeat (5) @(negedge clk);
      check("restart_idle_busy", 32'(busy), 32'd0);

      // Reset after two patterns aborts the run without done
      @(negedge clk);
      seed = 16'h00A5; weights = 16'h0000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      for (int c = 0; c < 10 && n < 2; c++) begin
         @(negedge clk);
         if (pat_en) n++;
      end
      check("rst_two_pats", 32'(n), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      check("rst_pat", 32'(pat), 32'h0);
      check("rst_pat_en", 32'(pat_en), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      rst = 1'b0;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done || pat_en || busy) bad++;
      end
      check("rst_no_done", 32'(bad), 32'd0);
      run_collect(16'h00A5, 16'h0000, 0, 0);
      check("replay_pat0", 32'(pats[0]), 32'hA5);
      check("replay_pat1", 32'(pats[1]), 32'h4A);
      check("replay_en_cnt", 32'(en_cnt), 32'd4);

`ifdef WRPG_BYPASS_EN
      bypass = 1'b1;
      run_collect(16'h00A5, 16'hFFFF, 0, 0);
      check("bypass_pat0", 32'(pats[0]), 32'hA5);
      check("bypass_pat1", 32'(pats[1]), 32'h4A);
      check("bypass_en_cnt", 32'(en_cnt), 32'd4);
      bypass = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wrpg_weight_gen.md
Name: wrpg_weight_gen

Overview:
- Upstream pattern source for the WRPG pattern register (8-bit dff with set/rst/en).
- Runs a 16-bit LFSR and biases each output bit with a per-bit 2-bit weight code, giving weighted random test patterns.
- Drives the register's d input from pat and its en input from pat_en.
- Emits exactly NUM_PAT patterns per start command, then pulses done.

Parameters:
- WIDTH, 8, pattern width; legal range 1..8, since the bit taps come from the fixed 16-bit LFSR.
- NUM_PAT, 16, patterns per run; legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; honoured only in IDLE.
- seed  in  16  LFSR seed, sampled in the start cycle.
- weights  in  2*WIDTH  per-bit weight code; bit i uses weights[2i+1:2i].
- hold  in  1  stall request; freezes generation while high.
- pat  out  WIDTH  weighted pattern (to register d).
- pat_en  out  1  new pattern valid this cycle (to register en).
- busy  out  1  high in SEED and RUN.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset: pat=0, pat_en=0, busy=0, done=0, r=16'hACE1, cnt=0, state=IDLE. Reset asserted mid-run aborts the run with no done pulse.
- LFSR: Fibonacci form with polynomial x^16+x^14+x^13+x^11+1.
  - fb = r[15]^r[13]^r[12]^r[10]; next r = {r[14:0], fb}.
  - A seed of 0 is replaced with 16'hACE1, because the all-zero state is a lockup.
- Weight map per bit i, with a=r[i], b=r[i+8], c=r[((i+4) mod 8)+8]:
  - 00: a (P=1/2)
  - 01: a&b (P=1/4)
  - 10: a|b (P=3/4)
  - 11: a&b&c (P=1/8)
- States:
  - IDLE: on start, load r (seed, or ACE1 if seed=0), cnt=0, go to SEED.
  - SEED: one cycle; busy=1; go to RUN.
  - RUN, cycle with hold=0: pat<=weight(r), pat_en<=1, r<=next(r), cnt<=cnt+1. If cnt==NUM_PAT-1, go to DONE.
  - RUN, cycle with hold=1: r, cnt and pat are frozen; pat_en<=0.
  - DONE: done=1 for one cycle, pat_en=0, pat holds its last value; go to IDLE.
- Latency: first pat_en is 2 cycles after the start cycle. Patterns are back-to-back while hold=0.
- Start is ignored outside IDLE. Hold outside RUN has no effect.
- Weights are sampled every RUN cycle. A mid-run change applies to the next pattern.
- pat_en is never high in IDLE, SEED or DONE. Over one run, the pat_en count is exactly NUM_PAT.
- cnt is 16-bit and never wraps within a run.

Optional Feature:
- Macro: WRPG_BYPASS_EN.
- Defined: adds input port bypass (1 bit). While bypass=1, pat = r[WIDTH-1:0] and the weights are ignored; the LFSR and counter are unchanged.
- Undefined: the port is absent and weighting always applies.

Decomposition:
- Package wrpg_pkg holds:
  - weight_e enum: W_HALF=00, W_QTR=01, W_3QTR=10, W_8TH=11.
  - state_e enum: IDLE, SEED, RUN, DONE.
  - LFSR_DEFAULT_SEED = 16'hACE1.
  - LFSR_TAPS constant.
- Sub-module wrpg_lfsr16 (ports: clk, rst, load, seed, step, r) holds the shift register and the zero-seed substitution.
- The FSM, weighting and counter stay in wrpg_weight_gen.

Test Plan:
- Basic sequence: weights=0, seed=16'h00A5, start, NUM_PAT=4 -> pat=8'hA5 then 8'h4A on the first two pat_en cycles. Exactly 4 pat_en pulses, done one cycle after the last, busy low after done.
- Weight codes: weights all 01 with seed=16'hFF0F -> first pat 8'h0F. All 10 with seed=16'h0F00 -> 8'h0F. All 11 with seed=16'hFFFF -> 8'hFF.
- Zero seed: seed=0, weights=0 -> first pat 8'hE1 (seed substituted with ACE1).
- Hold: hold=1 for 3 cycles after the first pattern -> pat_en low and pat stable for 3 cycles; the next pattern is 8'h4A (seed 00A5). Total pat_en count still NUM_PAT.
- Reset mid-run: rst asserted after 2 patterns -> next cycle pat=0, pat_en=0, busy=0, no done. A new start replays the run from the new seed.
- Start during RUN: second start pulse ignored -> pattern count and sequence unchanged. With WRPG_BYPASS_EN, bypass=1 and seed=16'h00A5 -> pat=8'hA5 for any weights.
